rvtu_rf_mp: RTL and testbench
=============================

RVTU_RF_MP -- requirements
Module: rvtu_rf_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, register width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of 2, >=4); AW = $clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter NWR, default 2, number of write ports.
REQ-005 SHALL have parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero.
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-007 SHALL have port rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port rd_addr  input  NRD*AW  read addresses; port i at [i*AW +: AW].
REQ-009 SHALL have port rd_data  output  NRD*XLEN  read data; combinational from rd_addr.
REQ-010 SHALL have port rd_pend  output  NRD  scoreboard pending bit of each read address.
REQ-011 SHALL have port wr_en  input  NWR  per-port write enable.
REQ-012 SHALL have port wr_addr  input  NWR*AW  write addresses.
REQ-013 SHALL have port wr_data  input  NWR*XLEN  write data.
REQ-014 SHALL have port sb_set  input  1  mark sb_addr pending.
REQ-015 SHALL have port sb_addr  input  AW  scoreboard set address.
REQ-016 SHALL have port clr_req  input  1  request a full clear of registers and scoreboard.
REQ-017 SHALL have port ready  output  1  1 = array initialised and accepting writes.

Function
REQ-018 SHALL implement FSM states CLEAR and RUN; rst forces CLEAR with clear index idx=0.
REQ-019 In CLEAR, SHALL write zero to register idx and clear its pending bit each cycle, incrementing idx; at idx=NREGS-1 SHALL go to RUN next cycle (CLEAR lasts exactly NREGS cycles).
REQ-020 ready SHALL be 1 only in RUN; 0 during reset and CLEAR.
REQ-021 In CLEAR, SHALL ignore wr_en and sb_set; rd_data SHALL return 0 and rd_pend 0.
REQ-022 clr_req in RUN SHALL move to CLEAR with idx=0 next cycle; writes in that same cycle still commit; clr_req in CLEAR SHALL be ignored.
REQ-023 rst asserted mid-CLEAR SHALL restart CLEAR at idx=0.
REQ-024 In RUN, wr_en[j] SHALL write wr_data[j] to wr_addr[j] at posedge (1-cycle write latency).
REQ-025 With ZERO_REG=1, writes to address 0 SHALL be dropped; reads of address 0 SHALL return 0 with rd_pend 0.
REQ-026 Multiple enabled write ports with equal address SHALL resolve to the highest-index port.
REQ-027 Read port SHALL bypass same-cycle write data: if any enabled write (RUN, non-dropped) matches rd_addr, rd_data SHALL equal the highest-index matching wr_data, else stored value.
REQ-028 Read ports SHALL be independent; any number may address the same register.
REQ-029 Pending bit of a register SHALL clear at posedge when any enabled write targets it.
REQ-030 sb_set in RUN SHALL set pending bit of sb_addr at posedge; set with same-cycle write to same address SHALL leave it set (set wins).
REQ-031 rd_pend SHALL reflect stored pending bits only (no bypass of same-cycle sb_set or write clear).
REQ-032 Address 0 pending bit SHALL never set when ZERO_REG=1.

Reset
REQ-033 rst SHALL be synchronous: at posedge with rst=1, state=CLEAR, idx=0, ready=0; register contents are then zeroed by the CLEAR sequence, not by rst directly.
REQ-034 After rst deasserts, ready SHALL rise exactly NREGS cycles later (32 for defaults).

Verification
REQ-035 Reset, release -> ready=0 for 32 cycles, 1 on 33rd; all reads return 0x00000000.
REQ-036 RUN: wr port0 r5=0xDEADBEEF, port1 r5=0x12345678 same cycle, rd_addr0=5 -> same-cycle rd_data=0x12345678; next cycle stored 0x12345678.
REQ-037 RUN: wr r0=0xFFFFFFFF -> rd r0 = 0, rd_pend 0.
REQ-038 sb_set r7 -> rd_pend=1 next cycle; wr r7=0x1 -> rd_pend=0 following cycle; sb_set r7 with wr r7 same cycle -> rd_pend stays 1.
REQ-039 r3=0xA5A5A5A5, clr_req -> ready=0 for 32 cycles, wr_en ignored throughout, then r3 reads 0.
REQ-040 rst asserted at CLEAR idx=10 -> ready rises exactly 32 cycles after rst deasserts.

Source files
------------

// File: rtl/rvtu_rf_mp.sv
// rvtu_rf_mp: multi-port register file with write bypass, pending scoreboard and sequenced clear
module rvtu_rf_mp #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter int NWR = 2,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_pend,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_addr,
  input  logic                 clr_req,
  output logic                 ready
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;
  function automatic logic dropped(input logic [AW-1:0] a);
    return ZERO_REG != 0 && a == '0;
  endfunction
  assign ready = state_q == RUN;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    regs_d = regs_q;
    pend_d = pend_q;
    if (state_q == CLEAR) begin
      regs_d[idx_q] = '0;
      pend_d[idx_q] = 1'b0;
      idx_d = idx_q + 1'b1;
      state_d = idx_q == AW'(NREGS - 1) ? RUN : CLEAR;
    end else begin
      for (int j = 0; j < NWR; j++)
        if (wr_en[j] && !dropped(wr_addr[j*AW +: AW])) begin
          regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
          pend_d[wr_addr[j*AW +: AW]] = 1'b0;
        end
      if (sb_set && !dropped(sb_addr)) pend_d[sb_addr] = 1'b1;
      state_d = clr_req ? CLEAR : RUN;
      idx_d = clr_req ? '0 : idx_q;
    end
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? CLEAR : state_d;
    idx_q <= rst ? '0 : idx_d;
    regs_q <= regs_d;
    pend_q <= pend_d;
  end
  always_comb begin
    rd_data = '0;
    rd_pend = '0;
    for (int i = 0; i < NRD; i++)
      if (state_q == RUN && !dropped(rd_addr[i*AW +: AW])) begin
        rd_data[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
        rd_pend[i] = pend_q[rd_addr[i*AW +: AW]];
        for (int j = 0; j < NWR; j++)
          if (wr_en[j] && wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])
            rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
      end
  end
endmodule

// File: tb/tb_rvtu_rf_mp.sv
// tb_rvtu_rf_mp: randomized and directed checks of rvtu_rf_mp against a behavioural model
module tb_rvtu_rf_mp;
  localparam int XLEN = 32, NREGS = 32, NRD = 2, NWR = 2, AW = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NRD*AW-1:0] rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0] rd_pend;
  logic [NWR-1:0] wr_en = '0;
  logic [NWR*AW-1:0] wr_addr = '0;
  logic [NWR*XLEN-1:0] wr_data = '0;
  logic sb_set = 1'b0;
  logic [AW-1:0] sb_addr = '0;
  logic clr_req = 1'b0;
  logic ready;
  logic [XLEN-1:0] mregs [NREGS];
  logic mpend [NREGS];
  int mrem = NREGS;
  int n_chk = 0;
  int n_fail = 0;
  rvtu_rf_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set),
    .sb_addr(sb_addr), .clr_req(clr_req), .ready(ready)
  );
  always #5 clk = ~clk;
  task automatic start_clear();
    mrem = NREGS;
    for (int r = 0; r < NREGS; r++) begin
      mregs[r] = '0;
      mpend[r] = 1'b0;
    end
  endtask
  task automatic model_update();
    logic [AW-1:0] a;
    if (rst) begin
      start_clear();
      return;
    end
    if (mrem > 0) begin
      mrem--;
      return;
    end
    for (int j = 0; j < NWR; j++) begin
      a = wr_addr[j*AW +: AW];
      if (wr_en[j] && a != 0) begin
        mregs[a] = wr_data[j*XLEN +: XLEN];
        mpend[a] = 1'b0;
      end
    end
    if (sb_set && sb_addr != 0) mpend[sb_addr] = 1'b1;
    if (clr_req) start_clear();
  endtask
  function automatic logic [NRD*XLEN-1:0] exp_data();
    logic [NRD*XLEN-1:0] r;
    logic [AW-1:0] a;
    logic [XLEN-1:0] v;
    r = '0;
    for (int i = 0; i < NRD; i++) begin
      a = rd_addr[i*AW +: AW];
      if (mrem == 0 && a != 0) begin
        v = mregs[a];
        for (int j = 0; j < NWR; j++)
          if (wr_en[j] && wr_addr[j*AW +: AW] == a) v = wr_data[j*XLEN +: XLEN];
        r[i*XLEN +: XLEN] = v;
      end
    end
    return r;
  endfunction
  function automatic logic [NRD-1:0] exp_pend();
    logic [NRD-1:0] r;
    r = '0;
    for (int i = 0; i < NRD; i++)
      r[i] = mrem == 0 && mpend[rd_addr[i*AW +: AW]];
    return r;
  endfunction
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask
  task automatic drive_random();
    rd_addr = NRD*AW'($urandom);
    wr_en = NWR'($urandom);
    wr_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
    wr_data = {$urandom, $urandom};
    sb_set = 1'($urandom);
    sb_addr = AW'($urandom_range(0, 7));
  endtask
  task automatic idle();
    wr_en = '0;
    sb_set = 1'b0;
    clr_req = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k <= NREGS; k++) begin
      if (k > 0) tick();
      drive_random();
      #1;
      n_chk++;
      if (ready !== (k == NREGS)) begin
        n_fail++;
        $display("FAIL reset_ready k=%0d got %b exp %b", k, ready, k == NREGS);
      end
      if (k < NREGS) begin
        n_chk++;
        if (rd_data !== '0 || rd_pend !== '0) begin
          n_fail++;
          $display("FAIL reset_clear_read k=%0d got %h/%b exp 0/0", k, rd_data, rd_pend);
        end
      end
    end
    idle();
    for (int r = 0; r < NREGS; r++) begin
      rd_addr = {AW'(r), AW'(r)};
      #1;
      n_chk++;
      if (rd_data !== '0 || rd_pend !== '0) begin
        n_fail++;
        $display("FAIL reset_zero r=%0d got %h/%b exp 0/0", r, rd_data, rd_pend);
      end
    end
  endtask
  task automatic test_write_priority();
    wr_en = 2'b11;
    wr_addr = {AW'(5), AW'(5)};
    wr_data = {32'h12345678, 32'hDEADBEEF};
    rd_addr = {AW'(5), AW'(5)};
    #1;
    n_chk++;
    if (rd_data !== {32'h12345678, 32'h12345678}) begin
      n_fail++;
      $display("FAIL prio_bypass got %h exp 1234567812345678", rd_data);
    end
    tick();
    idle();
    #1;
    n_chk++;
    if (rd_data[XLEN-1:0] !== 32'h12345678) begin
      n_fail++;
      $display("FAIL prio_stored got %h exp 12345678", rd_data[XLEN-1:0]);
    end
  endtask
  task automatic test_zero_reg();
    wr_en = 2'b01;
    wr_addr = {AW'(9), AW'(0)};
    wr_data = {32'h0, 32'hFFFFFFFF};
    sb_set = 1'b1;
    sb_addr = '0;
    rd_addr = {AW'(0), AW'(0)};
    #1;
    n_chk++;
    if (rd_data !== '0) begin
      n_fail++;
      $display("FAIL zero_bypass got %h exp 0", rd_data);
    end
    tick();
    idle();
    #1;
    n_chk++;
    if (rd_data !== '0 || rd_pend !== '0) begin
      n_fail++;
      $display("FAIL zero_stored got %h/%b exp 0/0", rd_data, rd_pend);
    end
  endtask
  task automatic test_scoreboard();
    rd_addr = {AW'(7), AW'(7)};
    sb_set = 1'b1;
    sb_addr = AW'(7);
    #1;
    n_chk++;
    if (rd_pend !== 2'b00) begin
      n_fail++;
      $display("FAIL sb_no_bypass got %b exp 00", rd_pend);
    end
    tick();
    idle();
    #1;
    n_chk++;
    if (rd_pend !== 2'b11) begin
      n_fail++;
      $display("FAIL sb_set got %b exp 11", rd_pend);
    end
    wr_en = 2'b01;
    wr_addr = {AW'(0), AW'(7)};
    wr_data = {32'h0, 32'h1};
    tick();
    idle();
    #1;
    n_chk++;
    if (rd_pend !== 2'b00 || rd_data !== {32'h1, 32'h1}) begin
      n_fail++;
      $display("FAIL sb_wr_clear got %b/%h exp 00/0000000100000001", rd_pend, rd_data);
    end
    wr_en = 2'b10;
    wr_addr = {AW'(7), AW'(0)};
    wr_data = {32'h2, 32'h0};
    sb_set = 1'b1;
    sb_addr = AW'(7);
    tick();
    idle();
    #1;
    n_chk++;
    if (rd_pend !== 2'b11) begin
      n_fail++;
      $display("FAIL sb_set_wins got %b exp 11", rd_pend);
    end
  endtask
  task automatic test_clear();
    wr_en = 2'b10;
    wr_addr = {AW'(3), AW'(0)};
    wr_data = {32'hA5A5A5A5, 32'h0};
    tick();
    idle();
    rd_addr = {AW'(3), AW'(3)};
    #1;
    n_chk++;
    if (rd_data !== {2{32'hA5A5A5A5}}) begin
      n_fail++;
      $display("FAIL clear_pre got %h exp a5a5a5a5a5a5a5a5", rd_data);
    end
    clr_req = 1'b1;
    tick();
    for (int k = 0; k <= NREGS; k++) begin
      if (k > 0) tick();
      wr_en = 2'b11;
      wr_addr = {AW'(3), AW'(3)};
      wr_data = {$urandom, $urandom};
      sb_set = 1'b1;
      sb_addr = AW'(3);
      clr_req = 1'($urandom);
      #1;
      n_chk++;
      if (ready !== (k == NREGS)) begin
        n_fail++;
        $display("FAIL clear_ready k=%0d got %b exp %b", k, ready, k == NREGS);
      end
      if (k < NREGS) begin
        n_chk++;
        if (rd_data !== '0 || rd_pend !== '0) begin
          n_fail++;
          $display("FAIL clear_read k=%0d got %h/%b exp 0/0", k, rd_data, rd_pend);
        end
      end
    end
    idle();
    #1;
    n_chk++;
    if (rd_data !== '0 || rd_pend !== '0) begin
      n_fail++;
      $display("FAIL clear_after got %h/%b exp 0/0", rd_data, rd_pend);
    end
  endtask
  task automatic test_rst_mid_clear();
    int n;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    n_chk++;
    if (n != NREGS) begin
      n_fail++;
      $display("FAIL rst_mid_clear cycles got %0d exp %0d", n, NREGS);
    end
  endtask
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive_random();
      clr_req = $urandom_range(0, 99) == 0;
      #1;
      n_chk++;
      if (ready !== (mrem == 0) || rd_data !== exp_data() || rd_pend !== exp_pend()) begin
        n_fail++;
        $display("FAIL random c=%0d got %b/%h/%b exp %b/%h/%b", c, ready, rd_data, rd_pend,
                 mrem == 0, exp_data(), exp_pend());
      end
      tick();
    end
    idle();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    start_clear();
    test_reset();
    test_write_priority();
    test_zero_reg();
    test_scoreboard();
    test_random();
    test_clear();
    test_rst_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
